// File: rtl/control_logic_core.sv
// Pipeline control decode: PC select, operand forwarding/selects, ALU op and decode squash.
// Optional macro WB2D_FWD_EN enables writeback-to-decode forwarding (wb2d_a/wb2d_b).
module control_logic_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_fd,
  input  logic [31:0] inst_x,
  input  logic [31:0] inst_mw,
  input  logic        brlt,
  input  logic        breq,
  output logic [1:0]  pc_sel,
  output logic        is_j_or_b,
  output logic        wb2d_a,
  output logic        wb2d_b,
  output logic        brun,
  output logic [1:0]  asel,
  output logic [1:0]  bsel,
  output logic [3:0]  alu_sel,
  output logic        kill_fd
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_JAL   = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_PLUS4 = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

`ifdef WB2D_FWD_EN
  localparam logic WB2D_EN = 1'b1;
`else
  localparam logic WB2D_EN = 1'b0;
`endif

  function automatic logic writes_rd(input logic [31:0] inst);
    return (inst[6:0] != OP_STORE) && (inst[6:0] != OP_BRANCH) && (inst[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] inst);
    return (inst[6:0] != OP_LUI) && (inst[6:0] != OP_AUIPC) && (inst[6:0] != OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [31:0] inst);
    return (inst[6:0] == OP_R) || (inst[6:0] == OP_STORE) || (inst[6:0] == OP_BRANCH);
  endfunction

  // Reserved branch funct3 codes (010/011) are treated as not taken.
  function automatic logic br_taken(input logic [2:0] f3, input logic lt, input logic eq);
    logic t;
    case (f3)
      3'b000:  t = eq;
      3'b001:  t = !eq;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = lt;
      3'b111:  t = !lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] alu_op(input logic [31:0] inst);
    logic [3:0] op;
    case (inst[6:0])
      OP_R:    op = {inst[30], inst[14:12]};
      OP_I:    op = {(inst[14:12] == 3'b101) ? inst[30] : 1'b0, inst[14:12]};
      OP_LUI:  op = ALU_PASSB;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0] x_op;
  logic       x_is_br;
  logic       mw_wr;
  logic       kill_fd_d;
  logic       kill_fd_q;

  assign x_op    = inst_x[6:0];
  assign x_is_br = (x_op == OP_BRANCH);
  assign mw_wr   = writes_rd(inst_mw);

  // Execute-stage redirect outranks a decode-stage jal.
  always_comb begin
    pc_sel = PC_PLUS4;
    if ((x_op == OP_JALR) || (x_is_br && br_taken(inst_x[14:12], brlt, breq))) begin
      pc_sel = PC_ALU;
    end else if (inst_fd[6:0] == OP_JAL) begin
      pc_sel = PC_JAL;
    end else begin
      pc_sel = PC_PLUS4;
    end
  end

  assign is_j_or_b = x_is_br || (x_op == OP_JAL) || (x_op == OP_JALR);
  assign brun      = x_is_br && (inst_x[14:13] == 2'b11);

  assign wb2d_a = WB2D_EN && mw_wr && uses_rs1(inst_fd) && (inst_mw[11:7] == inst_fd[19:15]);
  assign wb2d_b = WB2D_EN && mw_wr && uses_rs2(inst_fd) && (inst_mw[11:7] == inst_fd[24:20]);

  assign asel[1] = mw_wr && uses_rs1(inst_x) && (inst_mw[11:7] == inst_x[19:15]);
  assign asel[0] = (x_op == OP_AUIPC) || x_is_br || (x_op == OP_JAL);
  assign bsel[1] = mw_wr && uses_rs2(inst_x) && (inst_mw[11:7] == inst_x[24:20]);
  assign bsel[0] = (x_op != OP_R);
  assign alu_sel = alu_op(inst_x);

  assign kill_fd_d = (pc_sel != PC_PLUS4);

  // Squash flag for the instruction entering decode next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kill_fd_q <= 1'b0;
    end else begin
      kill_fd_q <= kill_fd_d;
    end
  end

  assign kill_fd = kill_fd_q;

endmodule

// File: tb/tb_control_logic_core.sv
// Scoreboard bench for control_logic_core: directed vectors plus random instruction mixes.
module tb_control_logic_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_fd, inst_x, inst_mw;
  logic        brlt, breq;
  logic [1:0]  pc_sel, asel, bsel;
  logic        is_j_or_b, wb2d_a, wb2d_b, brun, kill_fd;
  logic [3:0]  alu_sel;

  control_logic_core dut (
    .clk(clk), .rst_n(rst_n), .inst_fd(inst_fd), .inst_x(inst_x), .inst_mw(inst_mw),
    .brlt(brlt), .breq(breq), .pc_sel(pc_sel), .is_j_or_b(is_j_or_b), .wb2d_a(wb2d_a),
    .wb2d_b(wb2d_b), .brun(brun), .asel(asel), .bsel(bsel), .alu_sel(alu_sel), .kill_fd(kill_fd)
  );

  always #5 clk = ~clk;

`ifdef WB2D_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_UNK} kind_t;

  typedef struct {
    logic [1:0] pc_sel;
    logic       jb, wa, wb, brun;
    logic [1:0] asel, bsel;
    logic [3:0] alu;
    logic       kill;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic prev_rst = 1'b0;
  logic [1:0] prev_pc = 2'd2;

  function automatic kind_t kind_of(input logic [31:0] i);
    case (i[6:0])
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LD;
      7'h23:   return K_ST;
      7'h63:   return K_BR;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      7'h37:   return K_LUI;
      7'h17:   return K_AUIPC;
      default: return K_UNK;
    endcase
  endfunction

  function automatic int rd_of(input logic [31:0] i);  return int'(i[11:7]);  endfunction
  function automatic int rs1_of(input logic [31:0] i); return int'(i[19:15]); endfunction
  function automatic int rs2_of(input logic [31:0] i); return int'(i[24:20]); endfunction

  function automatic bit m_writes(input logic [31:0] i);
    kind_t k = kind_of(i);
    return !(k == K_ST || k == K_BR) && rd_of(i) != 0;
  endfunction
  function automatic bit m_rs1(input logic [31:0] i);
    kind_t k = kind_of(i);
    return !(k == K_LUI || k == K_AUIPC || k == K_JAL);
  endfunction
  function automatic bit m_rs2(input logic [31:0] i);
    kind_t k = kind_of(i);
    return k == K_R || k == K_ST || k == K_BR;
  endfunction

  function automatic bit m_taken(input logic [31:0] i, input bit lt, input bit eq);
    int f3 = int'(i[14:12]);
    if (f3 == 0) return eq;
    if (f3 == 1) return !eq;
    if (f3 == 4 || f3 == 6) return lt;
    if (f3 == 5 || f3 == 7) return !lt;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [31:0] fd, x, mw, input bit lt, eq);
    exp_t e;
    kind_t kx = kind_of(x);
    int f3 = int'(x[14:12]);
    if (kx == K_JALR || (kx == K_BR && m_taken(x, lt, eq))) e.pc_sel = 2'd1;
    else if (kind_of(fd) == K_JAL) e.pc_sel = 2'd0;
    else e.pc_sel = 2'd2;
    e.jb   = (kx == K_BR || kx == K_JAL || kx == K_JALR);
    e.brun = (kx == K_BR && f3 >= 6);
    e.wa   = FWD_ON && m_writes(mw) && m_rs1(fd) && rd_of(mw) == rs1_of(fd);
    e.wb   = FWD_ON && m_writes(mw) && m_rs2(fd) && rd_of(mw) == rs2_of(fd);
    e.asel[1] = m_writes(mw) && m_rs1(x) && rd_of(mw) == rs1_of(x);
    e.asel[0] = (kx == K_AUIPC || kx == K_BR || kx == K_JAL);
    e.bsel[1] = m_writes(mw) && m_rs2(x) && rd_of(mw) == rs2_of(x);
    e.bsel[0] = (kx != K_R);
    if (kx == K_R) e.alu = {x[30], x[14:12]};
    else if (kx == K_I) e.alu = (f3 == 5) ? {x[30], 3'b101} : {1'b0, x[14:12]};
    else if (kx == K_LUI) e.alu = 4'b1111;
    else e.alu = 4'b0000;
    e.kill = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the edge, drive new inputs #1 later, queue the expected response.
  task automatic apply(input logic [31:0] fd, x, mw, input bit lt, eq, rst);
    exp_t e;
    bit k;
    @(posedge clk);
    k = prev_rst ? (prev_pc != 2'd2) : 1'b0;
    #1;
    inst_fd = fd; inst_x = x; inst_mw = mw; brlt = lt; breq = eq; rst_n = rst;
    e = model(fd, x, mw, lt, eq);
    e.kill = k;
    exp_q.push_back(e);
    prev_rst = rst;
    prev_pc = e.pc_sel;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    int sel = int'($urandom_range(0, 9));
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    r[6:0]   = (sel < 9) ? ops[sel] : 7'($urandom);
    return r;
  endfunction

  // Monitor: the DUT presents a fresh response every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_sel", int'(pc_sel), int'(e.pc_sel));
        check("is_j_or_b", int'(is_j_or_b), int'(e.jb));
        check("wb2d_a", int'(wb2d_a), int'(e.wa));
        check("wb2d_b", int'(wb2d_b), int'(e.wb));
        check("brun", int'(brun), int'(e.brun));
        check("asel", int'(asel), int'(e.asel));
        check("bsel", int'(bsel), int'(e.bsel));
        check("alu_sel", int'(alu_sel), int'(e.alu));
        check("kill_fd", int'(kill_fd), int'(e.kill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] ADDI = 32'h00110193;
  localparam logic [31:0] BEQ  = 32'h00208463;

  initial begin
    rst_n = 1'b0; inst_fd = ADDI; inst_x = ADDI; inst_mw = ADDI; brlt = 1'b0; breq = 1'b0;

    apply(ADDI, ADDI, ADDI, 0, 0, 0);
    apply(ADDI, ADDI, ADDI, 0, 0, 1);
    #2 check("reset_kill", int'(kill_fd), 0);
    apply(32'h0040026F, ADDI, ADDI, 0, 0, 1);
    #2 check("jal_pcsel", int'(pc_sel), 0);
    apply(ADDI, 32'h00428267, ADDI, 0, 0, 1);
    #2 check("jalr_pcsel", int'(pc_sel), 1);
    check("jalr_jb", int'(is_j_or_b), 1);
    check("kill_after_jal", int'(kill_fd), 1);
    apply(ADDI, ADDI, ADDI, 0, 0, 1);
    #2 check("plus4_pcsel", int'(pc_sel), 2);
    check("kill_after_jalr", int'(kill_fd), 1);
    apply(ADDI, BEQ, ADDI, 0, 1, 1);
    #2 check("beq_taken", int'(pc_sel), 1);
    check("kill_after_plus4", int'(kill_fd), 0);
    apply(ADDI, BEQ, ADDI, 0, 0, 1);
    #2 check("beq_not_taken", int'(pc_sel), 2);
    apply(ADDI, 32'h0041E263, ADDI, 0, 0, 1);
    #2 check("bltu_brun", int'(brun), 1);
    apply(ADDI, 32'h00419A63, ADDI, 0, 0, 1);
    #2 check("bne_brun", int'(brun), 0);
    apply(32'h00318333, ADDI, ADDI, 0, 0, 1);
    #2 check("fwd_add_a", int'(wb2d_a), int'(FWD_ON));
    check("fwd_add_b", int'(wb2d_b), int'(FWD_ON));
    apply(32'h00350333, ADDI, ADDI, 0, 0, 1);
    #2 check("fwd_b_only_a", int'(wb2d_a), 0);
    check("fwd_b_only_b", int'(wb2d_b), int'(FWD_ON));
    apply(ADDI, 32'h0030A023, 32'h00012083, 0, 0, 1);
    #2 check("asel_sw", int'(asel), 2);
    apply(ADDI, 32'h010001EF, ADDI, 0, 0, 1);
    #2 check("asel_jal", int'(asel), 1);
    apply(ADDI, 32'h03266197, ADDI, 0, 0, 1);
    #2 check("asel_auipc", int'(asel), 1);
    apply(ADDI, 32'h00112223, 32'h00012083, 0, 0, 1);
    #2 check("bsel_sw_fwd", int'(bsel), 3);
    apply(ADDI, 32'h00518133, 32'h5A300293, 0, 0, 1);
    #2 check("bsel_r_fwd", int'(bsel), 2);
    apply(ADDI, 32'h0007B437, ADDI, 0, 0, 1);
    #2 check("bsel_lui", int'(bsel), 1);
    check("alu_lui", int'(alu_sel), 15);
    apply(ADDI, 32'h00428267, ADDI, 0, 0, 0);
    apply(ADDI, ADDI, ADDI, 0, 0, 1);
    #2 check("midrun_reset_kill", int'(kill_fd), 0);

    for (int n = 0; n < 400; n++) begin
      apply(rand_inst(), rand_inst(), rand_inst(), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 19) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    #1 check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
